// File: rtl/gg_deblock_pkg.sv
// Shared types and helpers for the deblocking back end: component indices,
// the 4x4 pixel block type and block-coordinate mapping.
package gg_deblock_pkg;

    localparam logic [2:0] CIDX_LUMA    = 3'd0;
    localparam logic [2:0] CIDX_ACLUMA  = 3'd1;
    localparam logic [2:0] CIDX_CB      = 3'd2;
    localparam logic [2:0] CIDX_CR      = 3'd3;
    localparam logic [2:0] CIDX_DC_LUMA = 3'd4;
    localparam logic [2:0] CIDX_DC_CB   = 3'd5;
    localparam logic [2:0] CIDX_DC_CR   = 3'd6;

    localparam int CW = 11;

    typedef logic [0:15][7:0] blk_t;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } blk_pos_t;

    // Luma MBs are 4x4 blocks with the H.264 zig-zag bidx; chroma MBs are 2x2.
    function automatic blk_pos_t blk_pos(input logic [2:0] cidx, input logic [3:0] bidx,
                                         input logic [7:0] mbx, input logic [7:0] mby);
        blk_pos_t p;
        if (cidx == CIDX_LUMA || cidx == CIDX_ACLUMA) begin
            p.x = {1'b0, mbx, 2'b00} + {9'd0, bidx[2], bidx[0]};
            p.y = {1'b0, mby, 2'b00} + {9'd0, bidx[3], bidx[1]};
        end else begin
            p.x = {2'b00, mbx, 1'b0} + {10'd0, bidx[0]};
            p.y = {2'b00, mby, 1'b0} + {10'd0, bidx[1]};
        end
        return p;
    endfunction

endpackage

// File: rtl/gg_multipush_fifo.sv
// Block-write FIFO accepting up to four pushes per cycle (all or nothing)
// and presenting a registered head for a single valid/ready pop.
module gg_multipush_fifo
    import gg_deblock_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 21
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               push_valid,
    input  logic [3:0][AW-1:0]       push_addr,
    input  blk_t [3:0]               push_data,
    input  logic                     pop_ready,
    output logic                     out_valid,
    output logic [AW-1:0]            out_addr,
    output blk_t                     out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [AW-1:0]   mem_addr [DEPTH];
    blk_t            mem_data [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr, rd_next;
    logic [3:0][2:0] slot_off;
    logic [2:0]      n, push_n;
    logic            found, fits, accept, pop;
    logic [AW-1:0]   first_addr;
    blk_t            first_data;
    logic [LW-1:0]   remain, level_next;

    // Compact the valid pushes into consecutive slots and check space against pre-pop level.
    always_comb begin
        n          = '0;
        found      = 1'b0;
        first_addr = '0;
        first_data = '0;
        slot_off   = '0;
        for (int k = 0; k < 4; k++) begin
            slot_off[k] = n;
            if (push_valid[k]) begin
                if (!found) begin
                    first_addr = push_addr[k];
                    first_data = push_data[k];
                    found      = 1'b1;
                end
                n = n + 3'd1;
            end
        end
        fits       = ((LW+1)'(level) + (LW+1)'(n)) <= (LW+1)'(DEPTH);
        accept     = fits && (n != 3'd0);
        drop       = !fits;
        pop        = out_valid && pop_ready;
        remain     = level - LW'(pop);
        push_n     = accept ? n : 3'd0;
        rd_next    = rd_ptr + PW'(pop);
        level_next = remain + LW'(push_n);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 4; k++) begin
                if (push_valid[k]) begin
                    mem_addr[wr_ptr + PW'(slot_off[k])] <= push_addr[k];
                    mem_data[wr_ptr + PW'(slot_off[k])] <= push_data[k];
                end
            end
        end
    end

    // When the stored entries run out, the head comes straight from this cycle's first push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            rd_ptr    <= rd_next;
            wr_ptr    <= wr_ptr + PW'(push_n);
            level     <= level_next;
            out_valid <= (level_next != '0);
            if (remain != '0) begin
                out_addr <= mem_addr[rd_next];
                out_data <= mem_data[rd_next];
            end else if (accept) begin
                out_addr <= first_addr;
                out_data <= first_data;
            end
        end
    end

endmodule

// File: rtl/gg_deblock_sink.sv
// Deblock back end: maps filtered neighbour blocks to frame-store block
// addresses, queues them and drains one block write per cycle.
module gg_deblock_sink
    import gg_deblock_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 21
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               mb_width,
    input  logic [7:0]               mb_height,
    input  logic                     in_valid,
    input  logic [7:0]               mbx,
    input  logic [7:0]               mby,
    input  logic [2:0]               cidx,
    input  logic [3:0]               bidx,
    input  logic                     ale_valid,
    input  logic                     abv_valid,
    input  logic                     lef_valid,
    input  logic                     cur_valid,
    input  blk_t                     ale_filt,
    input  blk_t                     abv_filt,
    input  blk_t                     lef_filt,
    input  blk_t                     cur_filt,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [AW-1:0]            wr_addr,
    output blk_t                     wr_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     edge_err
);

    logic              sample, edge_hit, drop;
    blk_pos_t          pos;
    logic [31:0]       luma_stride, luma_rows, chroma_stride, chroma_rows, stride, base;
    logic [31:0]       nx, ny;
    logic              step_left, step_up;
    logic [3:0]        raw_valid, off_pic, push_valid;
    logic [3:0][AW-1:0] push_addr;
    blk_t [3:0]        push_data;

    assign sample    = in_valid && !cidx[2];
    assign pos       = blk_pos(cidx, bidx, mbx, mby);
    assign raw_valid = {cur_valid, lef_valid, abv_valid, ale_valid};
    assign push_data = {cur_filt, lef_filt, abv_filt, ale_filt};

    // Plane layout: luma, then cb, then cr, each stored row-major in block units.
    always_comb begin
        luma_stride   = (32'(mb_width)  + 32'd1) << 2;
        luma_rows     = (32'(mb_height) + 32'd1) << 2;
        chroma_stride = (32'(mb_width)  + 32'd1) << 1;
        chroma_rows   = (32'(mb_height) + 32'd1) << 1;
        stride        = luma_stride;
        base          = '0;
        if (cidx == CIDX_CB) begin
            stride = chroma_stride;
            base   = luma_stride * luma_rows;
        end else if (cidx == CIDX_CR) begin
            stride = chroma_stride;
            base   = luma_stride * luma_rows + chroma_stride * chroma_rows;
        end
    end

    // Slot order is ale, abv, lef, cur; anything left of or above the picture is dropped.
    always_comb begin
        off_pic    = '0;
        push_valid = '0;
        push_addr  = '0;
        nx         = '0;
        ny         = '0;
        step_left  = 1'b0;
        step_up    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step_left     = (k == 0) || (k == 2);
            step_up       = (k < 2);
            off_pic[k]    = (step_left && pos.x == '0) || (step_up && pos.y == '0);
            nx            = 32'(pos.x) - (step_left ? 32'd1 : 32'd0);
            ny            = 32'(pos.y) - (step_up ? 32'd1 : 32'd0);
            push_addr[k]  = AW'(base + ny * stride + nx);
            push_valid[k] = sample && raw_valid[k] && !off_pic[k];
        end
        edge_hit = sample && ((raw_valid & off_pic) != 4'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            edge_err <= 1'b0;
        end else begin
            if (drop)     overflow <= 1'b1;
            if (edge_hit) edge_err <= 1'b1;
        end
    end

    gg_multipush_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_addr  (push_addr),
        .push_data  (push_data),
        .pop_ready  (wr_ready),
        .out_valid  (wr_valid),
        .out_addr   (wr_addr),
        .out_data   (wr_data),
        .level      (level),
        .drop       (drop)
    );

endmodule

// File: tb/tb_gg_deblock_sink.sv
// Randomised and directed bench for gg_deblock_sink against a queue-based
// model of block placement, FIFO ordering and sticky flags.
module tb_gg_deblock_sink;
    import gg_deblock_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 21;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mb_width, mb_height, mbx, mby;
    logic        in_valid;
    logic [2:0]  cidx;
    logic [3:0]  bidx;
    logic        ale_valid, abv_valid, lef_valid, cur_valid;
    blk_t        ale_filt, abv_filt, lef_filt, cur_filt;
    logic        wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    blk_t        wr_data;
    logic [$clog2(DEPTH):0] level;
    logic        overflow, edge_err;

    typedef struct {
        logic [AW-1:0] addr;
        logic [127:0]  data;
    } ent_t;

    ent_t q[$];
    logic m_overflow, m_edge;
    int   checks = 0;
    int   errors = 0;

    gg_deblock_sink #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .mb_width(mb_width), .mb_height(mb_height),
        .in_valid(in_valid), .mbx(mbx), .mby(mby), .cidx(cidx), .bidx(bidx),
        .ale_valid(ale_valid), .abv_valid(abv_valid), .lef_valid(lef_valid), .cur_valid(cur_valid),
        .ale_filt(ale_filt), .abv_filt(abv_filt), .lef_filt(lef_filt), .cur_filt(cur_filt),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .level(level), .overflow(overflow), .edge_err(edge_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic blk_t randBlk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // vmask bits: [3]=ale [2]=abv [1]=lef [0]=cur
    task automatic applyStimulus(input logic iv, input int mx, input int my, input int ci,
                                 input int bi, input logic [3:0] vmask, input logic rdy);
        in_valid  = iv;
        mbx       = 8'(mx);
        mby       = 8'(my);
        cidx      = 3'(ci);
        bidx      = 4'(bi);
        ale_valid = vmask[3];
        abv_valid = vmask[2];
        lef_valid = vmask[1];
        cur_valid = vmask[0];
        ale_filt  = randBlk();
        abv_filt  = randBlk();
        lef_filt  = randBlk();
        cur_filt  = randBlk();
        wr_ready  = rdy;
    endtask

    task automatic modelReset();
        q.delete();
        m_overflow = 1'b0;
        m_edge     = 1'b0;
    endtask

    // Reference behaviour for one rising edge, computed from picture geometry.
    task automatic modelUpdate();
        int x, y, base, stride, ls, lh, cs, ch;
        int nx[4], ny[4];
        logic v[4];
        logic [127:0] d[4];
        ent_t grp[$];
        logic pop;
        pop = (q.size() != 0) && wr_ready;
        if (in_valid && cidx < 4) begin
            ls = (int'(mb_width) + 1) * 4;
            lh = (int'(mb_height) + 1) * 4;
            cs = (int'(mb_width) + 1) * 2;
            ch = (int'(mb_height) + 1) * 2;
            if (cidx < 2) begin
                x = 4 * int'(mbx) + 2 * int'(bidx[2]) + int'(bidx[0]);
                y = 4 * int'(mby) + 2 * int'(bidx[3]) + int'(bidx[1]);
                base = 0;
                stride = ls;
            end else begin
                x = 2 * int'(mbx) + int'(bidx[0]);
                y = 2 * int'(mby) + int'(bidx[1]);
                base = (cidx == 2) ? ls * lh : ls * lh + cs * ch;
                stride = cs;
            end
            nx = '{x - 1, x, x - 1, x};
            ny = '{y - 1, y - 1, y, y};
            v  = '{ale_valid, abv_valid, lef_valid, cur_valid};
            d  = '{ale_filt, abv_filt, lef_filt, cur_filt};
            for (int k = 0; k < 4; k++) begin
                if (v[k]) begin
                    if (nx[k] < 0 || ny[k] < 0) m_edge = 1'b1;
                    else grp.push_back('{addr: AW'(base + ny[k] * stride + nx[k]), data: d[k]});
                end
            end
        end
        if (q.size() + grp.size() > DEPTH) begin
            m_overflow = 1'b1;
            grp.delete();
        end
        if (pop) void'(q.pop_front());
        foreach (grp[i]) q.push_back(grp[i]);
    endtask

    task automatic checkAll();
        checkOutput("wr_valid", 128'(wr_valid), 128'(q.size() != 0));
        checkOutput("level", 128'(level), 128'(q.size()));
        checkOutput("overflow", 128'(overflow), 128'(m_overflow));
        checkOutput("edge_err", 128'(edge_err), 128'(m_edge));
        if (q.size() != 0) begin
            checkOutput("wr_addr", 128'(wr_addr), 128'(q[0].addr));
            checkOutput("wr_data", 128'(wr_data), q[0].data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkAll();
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 0, 0, 0, 0, 4'b0000, rdy);
    endtask

    task automatic singleCur13();
        applyStimulus(1'b1, 0, 0, 0, 3, 4'b0001, 1'b1);
        step();
        checkOutput("s1_addr", 128'(wr_addr), 128'd13);
        checkOutput("s1_valid", 128'(wr_valid), 128'd1);
        idle(1'b1);
        step();
        checkOutput("s1_level", 128'(level), 128'd0);
    endtask

    initial begin
        reset     = 1'b1;
        mb_width  = 8'd2;
        mb_height = 8'd2;
        modelReset();
        idle(1'b1);
        repeat (2) @(negedge clk);
        checkAll();
        checkOutput("rst_addr", 128'(wr_addr), 128'd0);
        checkOutput("rst_data", 128'(wr_data), 128'd0);
        reset = 1'b0;

        singleCur13();

        applyStimulus(1'b1, 1, 0, 0, 0, 4'b0011, 1'b1);
        step();
        checkOutput("s2_first", 128'(wr_addr), 128'd3);
        idle(1'b1);
        step();
        checkOutput("s2_second", 128'(wr_addr), 128'd4);
        step();

        applyStimulus(1'b1, 1, 1, 2, 2, 4'b0001, 1'b1);
        step();
        checkOutput("s3_cb", 128'(wr_addr), 128'd164);
        applyStimulus(1'b1, 1, 1, 3, 2, 4'b0001, 1'b1);
        step();
        checkOutput("s3_cr", 128'(wr_addr), 128'd200);
        idle(1'b1);
        step();

        applyStimulus(1'b1, 0, 0, 0, 0, 4'b1111, 1'b1);
        step();
        checkOutput("s4_addr", 128'(wr_addr), 128'd0);
        checkOutput("s4_level", 128'(level), 128'd1);
        checkOutput("s4_edge", 128'(edge_err), 128'd1);
        idle(1'b1);
        step();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1, 1, 0, 0, 4'b1111, 1'b0);
            step();
            if (i == 7) checkOutput("s5_full", 128'(level), 128'd32);
        end
        checkOutput("s5_level", 128'(level), 128'd32);
        checkOutput("s5_ovf", 128'(overflow), 128'd1);
        idle(1'b1);
        for (int i = 0; i < 32; i++) step();
        checkOutput("s5_drained", 128'(level), 128'd0);

        applyStimulus(1'b1, 1, 1, 0, 0, 4'b1111, 1'b0);
        step();
        step();
        applyStimulus(1'b1, 1, 1, 0, 0, 4'b0011, 1'b0);
        step();
        idle(1'b0);
        checkOutput("s6_pre", 128'(level), 128'd10);
        reset = 1'b1;
        #1;
        checkOutput("s6_valid", 128'(wr_valid), 128'd0);
        checkOutput("s6_level", 128'(level), 128'd0);
        checkOutput("s6_ovf", 128'(overflow), 128'd0);
        checkOutput("s6_edge", 128'(edge_err), 128'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        singleCur13();

        mb_width  = 8'd3;
        mb_height = 8'd2;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 2),
                          $urandom_range(0, 7), $urandom_range(0, 15), 4'($urandom()),
                          ($urandom_range(0, 9) < 7));
            step();
        end
        idle(1'b1);
        for (int i = 0; i < 40; i++) step();
        checkOutput("final_level", 128'(level), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
